jts16_char_fetch: RTL and testbench

JTS16_CHAR_FETCH -- requirements
Module: jts16_char_fetch

---
 rtl/jts16_char_pkg.sv | 28 ++
 rtl/jts16_char_fetch_line.sv | 60 ++++++
 rtl/jts16_char_fetch.sv | 155 +++++++++++++++
 tb/tb_jts16_char_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jts16_char_pkg.sv
// Shared types and sizing for the char-layer ROM fetcher.
// Build option: define JTS16_CHAR_CACHE_EN for a two-line cache; otherwise
// a single line is kept and every tag change refetches.
package jts16_char_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } state_e;

    // Number of 16-bit SDRAM beats per char row
    localparam int unsigned BEATS = 2;

`ifdef JTS16_CHAR_CACHE_EN
    localparam int unsigned LINES = 2;
`else
    localparam int unsigned LINES = 1;
`endif

    localparam int unsigned AW       = 13;          // char_addr width
    localparam int unsigned SAW      = 22;          // SDRAM word address width
    localparam int unsigned SDW      = 16;          // SDRAM data beat width
    localparam int unsigned DW       = BEATS * SDW; // char row width
    localparam int unsigned VICTIM_W = 1;           // replacement pointer width

endpackage

// File: rtl/jts16_char_fetch_line.sv
// One cached char row: tag, 32-bit data, valid flag and a hit compare.
// Ports:
//   clk, rst      clock, async active-high reset
//   lookup_addr   address being looked up by the tile layer
//   we_lo         first beat: load data[15:0], invalidate the entry
//   we_hi         second beat: load data[31:16], set tag, mark valid
//   wr_tag        tag written with the second beat
//   wr_data       SDRAM beat data
//   hit_c         combinational hit (valid && tag match)
//   data          stored row
module jts16_char_fetch_line
    import jts16_char_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  lookup_addr,
    input  logic           we_lo,
    input  logic           we_hi,
    input  logic [AW-1:0]  wr_tag,
    input  logic [SDW-1:0] wr_data,
    output logic           hit_c,
    output logic [DW-1:0]  data
);

    logic [AW-1:0] tag_q,   tag_d;
    logic [DW-1:0] data_q,  data_d;
    logic          valid_q, valid_d;

    // Entry update; the entry is invalid while half-written
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (we_lo) begin
            data_d[SDW-1:0] = wr_data;
            valid_d         = 1'b0;
        end
        if (we_hi) begin
            data_d[DW-1:SDW] = wr_data;
            tag_d            = wr_tag;
            valid_d          = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign hit_c = valid_q && (tag_q == lookup_addr);
    assign data  = data_q;

endmodule

// File: rtl/jts16_char_fetch.sv
// Char-layer ROM fetcher: looks up the requested char row in a small line
// store and, on a miss, reads two 16-bit beats from the SDRAM slot.
// Build option: JTS16_CHAR_CACHE_EN selects two lines with least-recently-
// filled replacement; default is a single line.
// Ports:
//   clk, rst     clock, async active-high reset
//   char_addr    requested row, in 16-bit words
//   char_data    fetched row (valid when char_ok)
//   char_ok      registered hit for the previous cycle's char_addr
//   sdram_req    read request, held until sdram_ack
//   sdram_addr   BASE + fetch address, modulo 2^22
//   sdram_ack    request accepted
//   sdram_dok    one data beat valid on sdram_data
//   sdram_data   SDRAM read data
module jts16_char_fetch
    import jts16_char_pkg::*;
#(
    parameter logic [SAW-1:0] BASE = 22'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  char_addr,
    output logic [DW-1:0]  char_data,
    output logic           char_ok,
    output logic           sdram_req,
    output logic [SAW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           sdram_dok,
    input  logic [SDW-1:0] sdram_data
);

    state_e                state_q,      state_d;
    logic [AW-1:0]         fetch_addr_q, fetch_addr_d;
    logic                  sdram_req_q,  sdram_req_d;
    logic [SAW-1:0]        sdram_addr_q, sdram_addr_d;
    logic                  char_ok_q,    char_ok_d;
    logic [DW-1:0]         char_data_q,  char_data_d;
    logic [VICTIM_W-1:0]   victim_q,     victim_d;

    logic                  we_lo, we_hi;
    logic [LINES-1:0]      hit_vec, we_lo_vec, we_hi_vec;
    logic [DW-1:0]         line_data [LINES];
    logic                  hit_any, hit_victim;
    logic [DW-1:0]         hit_data;

    for (genvar g = 0; g < LINES; g++) begin : g_line
        jts16_char_fetch_line u_line (
            .clk         (clk),
            .rst         (rst),
            .lookup_addr (char_addr),
            .we_lo       (we_lo_vec[g]),
            .we_hi       (we_hi_vec[g]),
            .wr_tag      (fetch_addr_q),
            .wr_data     (sdram_data),
            .hit_c       (hit_vec[g]),
            .data        (line_data[g])
        );
    end

    // Hit select and write steering to the victim line
    always_comb begin
        hit_any    = 1'b0;
        hit_victim = 1'b0;
        hit_data   = '0;
        we_lo_vec  = '0;
        we_hi_vec  = '0;
        for (int i = 0; i < LINES; i++) begin
            if (hit_vec[i]) begin
                hit_any  = 1'b1;
                hit_data = line_data[i];
                if (victim_q == VICTIM_W'(i)) hit_victim = 1'b1;
            end
            if (victim_q == VICTIM_W'(i)) begin
                we_lo_vec[i] = we_lo;
                we_hi_vec[i] = we_hi;
            end
        end
    end

    // Fetch FSM and registered outputs
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        victim_d     = victim_q;
        we_lo        = 1'b0;
        we_hi        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!hit_any) begin
                    fetch_addr_d = char_addr;
                    sdram_addr_d = BASE + SAW'(char_addr);
                    sdram_req_d  = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    state_d     = BEAT0;
                end
            end
            BEAT0: begin
                if (sdram_dok) begin
                    we_lo   = 1'b1;
                    state_d = BEAT1;
                end
            end
            BEAT1: begin
                if (sdram_dok) begin
                    we_hi   = 1'b1;
                    state_d = IDLE;
`ifdef JTS16_CHAR_CACHE_EN
                    victim_d = ~victim_q;
`else
                    victim_d = victim_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A line being overwritten this cycle must not report a hit next cycle
        char_ok_d   = hit_any && !(hit_victim && (we_lo || we_hi));
        char_data_d = hit_any ? hit_data : char_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= BASE;
            char_ok_q    <= 1'b0;
            char_data_q  <= '0;
            victim_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            char_ok_q    <= char_ok_d;
            char_data_q  <= char_data_d;
            victim_q     <= victim_d;
        end
    end

    assign char_ok    = char_ok_q;
    assign char_data  = char_data_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jts16_char_fetch.sv
module tb_jts16_char_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] char_addr;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] sdram_data;

    logic [31:0] char_data,  w_char_data;
    logic        char_ok,    w_char_ok;
    logic        sdram_req,  w_sdram_req;
    logic [21:0] sdram_addr, w_sdram_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jts16_char_fetch #(.BASE(22'h100000)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    // Second instance near the top of the address space to exercise wrap
    jts16_char_fetch #(.BASE(22'h3FFFF0)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .char_addr  (char_addr),
        .char_data  (w_char_data),
        .char_ok    (w_char_ok),
        .sdram_req  (w_sdram_req),
        .sdram_addr (w_sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after the edge that raised sdram_req; returns just after
    // the edge that captured the second beat.
    task automatic fetch(input int ack_dly, input logic [21:0] exp_addr,
                         input logic [15:0] lo, input logic [15:0] hi);
        chk("req_rise", 32'(sdram_req), 32'd1);
        chk("req_addr", 32'(sdram_addr), 32'(exp_addr));
        repeat (ack_dly) begin
            tick;
            chk("req_hold", 32'(sdram_req), 32'd1);
            chk("addr_hold", 32'(sdram_addr), 32'(exp_addr));
        end
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        chk("req_drop", 32'(sdram_req), 32'd0);
        sdram_dok  = 1'b1;
        sdram_data = lo;
        tick;
        sdram_data = hi;
        tick;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0;
    endtask

    initial begin
        rst        = 1'b1;
        char_addr  = 13'h0;
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0;
        tick;
        tick;

        // Reset state
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_ok", 32'(char_ok), 32'd0);
        chk("rst_data", char_data, 32'h0);
        chk("rst_addr", 32'(sdram_addr), 32'h100000);
        chk("rst_addr_w", 32'(w_sdram_addr), 32'h3FFFF0);

        // Basic fetch at minimum latency: 5 cycles from address change
        rst       = 1'b0;
        char_addr = 13'h0010;
        tick;
        chk("wrap_10", 32'(w_sdram_addr), 32'h000000);
        fetch(0, 22'h100010, 16'h1234, 16'hABCD);
        chk("lat4_ok", 32'(char_ok), 32'd0);
        tick;
        chk("lat5_ok", 32'(char_ok), 32'd1);
        chk("t1_data", char_data, 32'hABCD1234);
        chk("t1_noreq", 32'(sdram_req), 32'd0);

        // Stray beat while idle on a hit is ignored
        sdram_dok  = 1'b1;
        sdram_data = 16'hDEAD;
        tick;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0;
        tick;
        chk("idle_dok_ok", 32'(char_ok), 32'd1);
        chk("idle_dok_data", char_data, 32'hABCD1234);
        chk("idle_dok_req", 32'(sdram_req), 32'd0);

        // Slow ack with stray beats during REQ
        char_addr = 13'h0030;
        tick;
        sdram_dok  = 1'b1;
        sdram_data = 16'hBEEF;
        fetch(20, 22'h100030, 16'h5555, 16'h6666);
        tick;
        chk("t2_ok", 32'(char_ok), 32'd1);
        chk("t2_data", char_data, 32'h66665555);

        // Reset during BEAT1, then stray beats
        char_addr = 13'h0050;
        tick;
        chk("t4_req", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick;
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b1;
        sdram_data = 16'hAAAA;
        tick;
        sdram_dok  = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(sdram_req), 32'd0);
        chk("mid_rst_ok", 32'(char_ok), 32'd0);
        chk("mid_rst_addr", 32'(sdram_addr), 32'h100000);
        sdram_dok  = 1'b1;
        sdram_data = 16'hCCCC;
        tick;
        tick;
        rst = 1'b0;
        tick;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0;
        chk("post_rst_ok", 32'(char_ok), 32'd0);
        fetch(0, 22'h100050, 16'h7777, 16'h8888);
        chk("t4_fill_ok0", 32'(char_ok), 32'd0);
        tick;
        chk("t4_ok", 32'(char_ok), 32'd1);
        chk("t4_data", char_data, 32'h88887777);

        // Address change during BEAT0: old fill completes, then new request
        char_addr = 13'h0010;
        tick;
        chk("t3_req", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick;
        sdram_ack  = 1'b0;
        char_addr  = 13'h0020;
        sdram_dok  = 1'b1;
        sdram_data = 16'h1111;
        tick;
        sdram_data = 16'h2222;
        tick;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0;
        chk("t3_ok_a", 32'(char_ok), 32'd0);
        chk("t3_noreq", 32'(sdram_req), 32'd0);
        tick;
        chk("t3_ok_b", 32'(char_ok), 32'd0);
        chk("wrap_20", 32'(w_sdram_addr), 32'h000010);
        fetch(0, 22'h100020, 16'h3333, 16'h4444);
        tick;
        chk("t3_ok", 32'(char_ok), 32'd1);
        chk("t3_data", char_data, 32'h44443333);

        // Return to 0x10: cached hit or refetch depending on the build
        char_addr = 13'h0010;
        tick;
`ifdef JTS16_CHAR_CACHE_EN
        chk("c_ok", 32'(char_ok), 32'd1);
        chk("c_noreq", 32'(sdram_req), 32'd0);
        chk("c_data", char_data, 32'h22221111);
`else
        chk("nc_ok", 32'(char_ok), 32'd0);
        fetch(0, 22'h100010, 16'h1111, 16'h2222);
        tick;
        chk("nc_ok2", 32'(char_ok), 32'd1);
        chk("nc_data", char_data, 32'h22221111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
